lsu_axi_bridge: RTL and testbench

LSU_AXI_BRIDGE -- requirements
Module: lsu_axi_bridge

---
 rtl/lsu_axi_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_axi_bridge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_bridge.sv
// Bridges a simple LSU load/store request port onto an AXI4-Lite master.
// One transaction at a time; sub-word accesses are lane-shifted to/from the aligned bus word.
module lsu_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic              lsu_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RSP} state_t;

  // Strobes wider than a word cannot be carried on a 32-bit bus, so they are rejected too.
  function automatic logic misaligned(input logic [7:0] strb, input logic [1:0] off);
    if (|strb[7:4])             return 1'b1;
    else if (strb[3] | strb[2]) return (off != 2'b00);
    else if (strb[1])           return off[0];
    else                        return 1'b0;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [1:0]          off_q, off_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                store_q, store_d;
  logic                err_q, err_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                aw_nxt, w_nxt;
  logic                arvalid_q, awvalid_q, wvalid_q, rready_q, bready_q;
  logic                lsu_rvalid_q, lsu_wready_q, lsu_err_q;

  always_comb begin
    state_d    = state_q;
    bus_addr_d = bus_addr_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    store_d    = store_q;
    err_d      = err_q;
    aw_done_d  = 1'b0;
    w_done_d   = 1'b0;
    aw_nxt     = aw_done_q | (awvalid_q & awready);
    w_nxt      = w_done_q | (wvalid_q & wready);
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (lsu_awvalid && lsu_wvalid) begin
          store_d    = 1'b1;
          bus_addr_d = {lsu_awaddr[ADDR_W-1:2], 2'b00};
          off_d      = lsu_awaddr[1:0];
          wdata_d    = lsu_wdata << {lsu_awaddr[1:0], 3'b000};
          wstrb_d    = lsu_wstrb[3:0] << lsu_awaddr[1:0];
          if (misaligned(lsu_wstrb, lsu_awaddr[1:0])) begin
            err_d   = 1'b1;
            state_d = RSP;
          end else begin
            state_d = WR_AW;
          end
        end else if (lsu_arvalid) begin
          store_d    = 1'b0;
          bus_addr_d = {lsu_araddr[ADDR_W-1:2], 2'b00};
          off_d      = lsu_araddr[1:0];
          if (misaligned(lsu_rstrb, lsu_araddr[1:0])) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RSP;
          end else begin
            state_d = RD_A;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_A: begin
        if (arvalid_q && arready) state_d = RD_D;
        else                      state_d = RD_A;
      end
      RD_D: begin
        if (rvalid) begin
          rdata_d = rdata >> {off_q, 3'b000};
          err_d   = (rresp != 2'b00);
          state_d = RSP;
        end else begin
          state_d = RD_D;
        end
      end
      WR_AW: begin
        // AW and W complete independently; flags clear once both are done.
        if (aw_nxt && w_nxt) begin
          state_d = WR_B;
        end else begin
          aw_done_d = aw_nxt;
          w_done_d  = w_nxt;
          state_d   = WR_AW;
        end
      end
      WR_B: begin
        if (bvalid) begin
          err_d   = (bresp != 2'b00);
          state_d = RSP;
        end else begin
          state_d = WR_B;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus and LSU handshake outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bus_addr_q   <= '0;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      wstrb_q      <= 4'h0;
      rdata_q      <= '0;
      store_q      <= 1'b0;
      err_q        <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      rready_q     <= 1'b0;
      bready_q     <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      lsu_wready_q <= 1'b0;
      lsu_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_addr_q   <= bus_addr_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      store_q      <= store_d;
      err_q        <= err_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      arvalid_q    <= (state_d == RD_A);
      awvalid_q    <= (state_d == WR_AW) && !aw_done_d;
      wvalid_q     <= (state_d == WR_AW) && !w_done_d;
      rready_q     <= (state_d == RD_D);
      bready_q     <= (state_d == WR_B);
      lsu_rvalid_q <= (state_d == RSP) && !store_d;
      lsu_wready_q <= (state_d == RSP) && store_d;
      lsu_err_q    <= (state_d == RSP) && err_d;
    end
  end

  assign araddr     = bus_addr_q;
  assign awaddr     = bus_addr_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign arvalid    = arvalid_q;
  assign awvalid    = awvalid_q;
  assign wvalid     = wvalid_q;
  assign rready     = rready_q;
  assign bready     = bready_q;
  assign lsu_rdata  = rdata_q;
  assign lsu_rvalid = lsu_rvalid_q;
  assign lsu_wready = lsu_wready_q;
  assign lsu_err    = lsu_err_q;

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Directed bench for lsu_axi_bridge: slave behaviour is driven step by step, outputs sampled 1ns after each edge.
module tb_lsu_axi_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lsu_araddr = 32'h0;
  logic        lsu_arvalid = 1'b0;
  logic [7:0]  lsu_rstrb = 8'h0;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic [31:0] lsu_awaddr = 32'h0;
  logic        lsu_awvalid = 1'b0;
  logic [31:0] lsu_wdata = 32'h0;
  logic [7:0]  lsu_wstrb = 8'h0;
  logic        lsu_wvalid = 1'b0;
  logic        lsu_wready, lsu_err;
  logic [31:0] araddr, awaddr, wdata, rdata = 32'h0;
  logic        arvalid, arready = 1'b0;
  logic [1:0]  rresp = 2'b00, bresp = 2'b00;
  logic        rvalid = 1'b0, rready;
  logic        awvalid, awready = 1'b0;
  logic [3:0]  wstrb;
  logic        wvalid, wready = 1'b0;
  logic        bvalid = 1'b0, bready;
  int          checks = 0;
  int          errors = 0;

  lsu_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_err(lsu_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_rvalid"}, lsu_rvalid, 1'b0);
    chk1({tag, "_wready"}, lsu_wready, 1'b0);
    chk1({tag, "_err"}, lsu_err, 1'b0);
    chk32({tag, "_lsu_rdata"}, lsu_rdata, 32'h0);
    chk1({tag, "_arvalid"}, arvalid, 1'b0);
    chk1({tag, "_awvalid"}, awvalid, 1'b0);
    chk1({tag, "_wvalid"}, wvalid, 1'b0);
    chk1({tag, "_rready"}, rready, 1'b0);
    chk1({tag, "_bready"}, bready, 1'b0);
    chk32({tag, "_araddr"}, araddr, 32'h0);
    chk32({tag, "_awaddr"}, awaddr, 32'h0);
    chk32({tag, "_wdata"}, wdata, 32'h0);
    chk4({tag, "_wstrb"}, wstrb, 4'h0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // LW 0x80000010, two wait cycles on R
    lsu_araddr = 32'h8000_0010; lsu_rstrb = 8'h0F; lsu_arvalid = 1'b1;
    tick();
    lsu_arvalid = 1'b0;
    chk1("lw_arvalid", arvalid, 1'b1);
    chk32("lw_araddr", araddr, 32'h8000_0010);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk1("lw_arvalid_drop", arvalid, 1'b0);
    chk1("lw_rready", rready, 1'b1);
    tick();
    chk1("lw_wait1_rvalid", lsu_rvalid, 1'b0);
    tick();
    chk1("lw_wait2_rready", rready, 1'b1);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    tick();
    rvalid = 1'b0;
    chk1("lw_rsp_rvalid", lsu_rvalid, 1'b1);
    chk32("lw_rsp_rdata", lsu_rdata, 32'hDEAD_BEEF);
    chk1("lw_rsp_err", lsu_err, 1'b0);
    chk1("lw_rsp_rready", rready, 1'b0);
    tick();
    chk1("lw_pulse_end", lsu_rvalid, 1'b0);
    chk32("lw_rdata_hold", lsu_rdata, 32'hDEAD_BEEF);

    // LB 0x80000013, zero-wait slave: pulse 3 cycles after acceptance
    lsu_araddr = 32'h8000_0013; lsu_rstrb = 8'h01; lsu_arvalid = 1'b1;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hAB00_0000;
    tick();
    lsu_arvalid = 1'b0;
    chk32("lb_araddr", araddr, 32'h8000_0010);
    chk1("lb_lat1", lsu_rvalid, 1'b0);
    tick();
    chk1("lb_lat2", lsu_rvalid, 1'b0);
    tick();
    arready = 1'b0; rvalid = 1'b0;
    chk1("lb_rvalid", lsu_rvalid, 1'b1);
    chk32("lb_rdata", lsu_rdata, 32'h0000_00AB);
    tick();

    // SH 0x80000002 data 0x1234
    lsu_awaddr = 32'h8000_0002; lsu_wdata = 32'h0000_1234; lsu_wstrb = 8'h03;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    tick();
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    chk1("sh_awvalid", awvalid, 1'b1);
    chk1("sh_wvalid", wvalid, 1'b1);
    chk32("sh_awaddr", awaddr, 32'h8000_0000);
    chk32("sh_wdata", wdata, 32'h1234_0000);
    chk4("sh_wstrb", wstrb, 4'hC);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    chk1("sh_awvalid_drop", awvalid, 1'b0);
    chk1("sh_bready", bready, 1'b1);
    chk1("sh_no_early_wready", lsu_wready, 1'b0);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk1("sh_wready_pulse", lsu_wready, 1'b1);
    chk1("sh_err", lsu_err, 1'b0);
    tick();
    chk1("sh_pulse_end", lsu_wready, 1'b0);

    // Simultaneous store and load: store first, load right after RSP
    lsu_awaddr = 32'h8000_0020; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 8'h0F;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    lsu_araddr = 32'h8000_0040; lsu_rstrb = 8'h0F; lsu_arvalid = 1'b1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    tick();
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    chk1("pri_awvalid", awvalid, 1'b1);
    chk1("pri_arvalid", arvalid, 1'b0);
    chk32("pri_wdata", wdata, 32'hCAFE_F00D);
    tick();
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b1;
    chk1("pri_store_rsp", lsu_wready, 1'b1);
    chk1("pri_no_ar_yet", arvalid, 1'b0);
    tick();
    chk1("pri_idle_arvalid", arvalid, 1'b0);
    tick();
    lsu_arvalid = 1'b0;
    chk1("pri_load_arvalid", arvalid, 1'b1);
    chk32("pri_load_araddr", araddr, 32'h8000_0040);
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1122_3344;
    tick();
    rvalid = 1'b0;
    chk1("pri_load_rvalid", lsu_rvalid, 1'b1);
    chk32("pri_load_rdata", lsu_rdata, 32'h1122_3344);
    tick();

    // SW with awready 3 cycles after wready, SLVERR response
    lsu_awaddr = 32'h8000_0004; lsu_wdata = 32'h55AA_55AA; lsu_wstrb = 8'h0F;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    tick();
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    wready = 1'b1;
    tick();
    wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("split_awvalid_held", awvalid, 1'b1);
      chk1("split_wvalid_drop", wvalid, 1'b0);
      chk1("split_no_bready", bready, 1'b0);
      if (i == 2) awready = 1'b1;
      tick();
    end
    awready = 1'b0;
    chk1("split_awvalid_drop", awvalid, 1'b0);
    chk1("split_bready", bready, 1'b1);
    bvalid = 1'b1; bresp = 2'b10;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    chk1("split_wready", lsu_wready, 1'b1);
    chk1("split_err", lsu_err, 1'b1);
    tick();
    chk1("split_err_end", lsu_err, 1'b0);

    // Misaligned LW: direct response, err, rdata cleared, nothing on bus
    lsu_araddr = 32'h8000_0002; lsu_rstrb = 8'h0F; lsu_arvalid = 1'b1;
    tick();
    lsu_arvalid = 1'b0;
    chk1("mis_lw_rvalid", lsu_rvalid, 1'b1);
    chk1("mis_lw_err", lsu_err, 1'b1);
    chk32("mis_lw_rdata", lsu_rdata, 32'h0);
    chk1("mis_lw_arvalid", arvalid, 1'b0);
    tick();

    // Misaligned SH
    lsu_awaddr = 32'h8000_0001; lsu_wdata = 32'h0000_BEEF; lsu_wstrb = 8'h03;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    tick();
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    chk1("mis_sh_wready", lsu_wready, 1'b1);
    chk1("mis_sh_err", lsu_err, 1'b1);
    chk1("mis_sh_awvalid", awvalid, 1'b0);
    chk1("mis_sh_wvalid", wvalid, 1'b0);
    tick();

    // Reset while in RD_D, late rvalid ignored
    lsu_araddr = 32'h8000_0100; lsu_rstrb = 8'h0F; lsu_arvalid = 1'b1; arready = 1'b1;
    tick();
    lsu_arvalid = 1'b0;
    tick();
    arready = 1'b0;
    chk1("rst_mid_rready", rready, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'h0000_0099;
    chk_all_zero("rst_mid");
    tick();
    rvalid = 1'b0;
    chk_all_zero("rst_late");
    tick();
    chk1("rst_after_rvalid", lsu_rvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
